stack_mem_responder: RTL and testbench

//  Memory-side responder for the stack machine core bus (mem_addr, mem_write, mem_data).

---
 rtl/stack_mem_responder.sv | 167 ++++++++++++++++
 tb/tb_stack_mem_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_mem_responder.sv
// stack_mem_responder
// Memory-side responder for the stack machine core bus. Holds the program
// and data store, serves core reads on the shared mem_data bus, absorbs core
// writes, and contains a boot loader that streams a program image into the
// store from address 0 while the core is held in reset.
module stack_mem_responder #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 2048,
    parameter int BOOT_LOAD = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_write,
    inout  wire  [DATA_W-1:0] mem_data,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              core_rst,
    output logic [ADDR_W-1:0] load_count
);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t            RESET_STATE = (BOOT_LOAD != 0) ? ST_LOAD : ST_RUN;
    localparam logic              RESET_CORE  = (BOOT_LOAD != 0) ? 1'b1 : 1'b0;
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE_ADDR    = ADDR_W'(1);

    state_t              state_r;
    state_t              state_n;
    logic [ADDR_W-1:0]   load_count_r;
    logic [ADDR_W-1:0]   load_count_n;
    logic                core_rst_r;
    logic                core_rst_n;

    logic                accept_s;
    logic                at_end_s;
    logic                in_range_s;
    logic                drive_en_s;
    logic [DATA_W-1:0]   rd_data_s;
    logic                wr_en_s;
    logic [ADDR_W-1:0]   wr_addr_s;
    logic [DATA_W-1:0]   wr_data_s;

    // The store is not cleared by reset; it powers up as all zeros so that a
    // design built without a boot image still reads defined values.
    logic [DATA_W-1:0]   mem_r [DEPTH] = '{default: '0};

    // When the store spans the whole address space every address is valid,
    // otherwise addresses at or above DEPTH read as zero and drop writes.
    generate
        if (DEPTH < (2 ** ADDR_W)) begin : g_partial_map
            localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
            assign in_range_s = (mem_addr < DEPTH_A);
        end else begin : g_full_map
            assign in_range_s = 1'b1;
        end
    endgenerate

    assign load_ready = (state_r == ST_LOAD) & ~rst;
    assign accept_s   = load_valid & load_ready;
    assign at_end_s   = (load_count_r == LAST_ADDR);
    assign core_rst   = core_rst_r;
    assign load_count = load_count_r;

    // The enable is purely combinational so the responder releases the bus in
    // the very cycle the core starts a write: there is no overlap cycle.
    assign drive_en_s = (state_r == ST_RUN) & ~mem_write & ~rst;
    assign mem_data   = drive_en_s ? rd_data_s : {DATA_W{1'bz}};

    // Asynchronous read path, zero for unmapped addresses.
    always_comb begin
        rd_data_s = '0;
        if (in_range_s) begin
            rd_data_s = mem_r[mem_addr];
        end else begin
            rd_data_s = '0;
        end
    end

    // Next-state logic: loader acceptance, counter saturation, core release.
    always_comb begin
        state_n      = state_r;
        load_count_n = load_count_r;
        core_rst_n   = core_rst_r;
        case (state_r)
            ST_LOAD: begin
                if (accept_s) begin
                    if (at_end_s) begin
                        load_count_n = load_count_r;
                    end else begin
                        load_count_n = load_count_r + ONE_ADDR;
                    end
                    if (load_last || at_end_s) begin
                        state_n    = ST_RUN;
                        core_rst_n = 1'b0;
                    end else begin
                        state_n    = ST_LOAD;
                        core_rst_n = 1'b1;
                    end
                end else begin
                    state_n = ST_LOAD;
                end
            end
            ST_RUN: begin
                state_n    = ST_RUN;
                core_rst_n = 1'b0;
            end
            default: begin
                state_n      = RESET_STATE;
                load_count_n = '0;
                core_rst_n   = RESET_CORE;
            end
        endcase
    end

    // Write port select: loader words in LOAD, core writes in RUN.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = '0;
        wr_data_s = '0;
        case (state_r)
            ST_LOAD: begin
                wr_en_s   = accept_s;
                wr_addr_s = load_count_r;
                wr_data_s = load_data;
            end
            ST_RUN: begin
                wr_en_s   = mem_write & ~rst & in_range_s;
                wr_addr_s = mem_addr;
                wr_data_s = mem_data;
            end
            default: begin
                wr_en_s   = 1'b0;
                wr_addr_s = '0;
                wr_data_s = '0;
            end
        endcase
    end

    // State, load counter and core reset registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= RESET_STATE;
            load_count_r <= '0;
            core_rst_r   <= RESET_CORE;
        end else begin
            state_r      <= state_n;
            load_count_r <= load_count_n;
            core_rst_r   <= core_rst_n;
        end
    end

    // Single write port into the store.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_addr_s] <= wr_data_s;
        end
    end

endmodule

// File: tb/tb_stack_mem_responder.sv
// Bench for stack_mem_responder: a boot-loading instance with the full
// 2048-word store and a no-boot instance with a 1024-word store so that
// unmapped addresses can be exercised.
module tb_stack_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_last;

    logic [10:0] addr0, addr1;
    logic        wr0, wr1;
    logic        en0, en1;
    logic [15:0] drv0, drv1;
    wire  [15:0] bus0, bus1;

    logic        lr0, cr0, lr1, cr1;
    logic [10:0] lc0, lc1;

    int checks = 0;
    int passes = 0;
    logic [15:0] sb_q[$];

    typedef struct {
        logic        wr;
        logic [10:0] addr;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    vec_t run_tbl[10];
    vec_t oor_tbl[6];

    always #5 clk = ~clk;

    assign bus0 = en0 ? drv0 : 16'hzzzz;
    assign bus1 = en1 ? drv1 : 16'hzzzz;

    stack_mem_responder #(.ADDR_W(11), .DATA_W(16), .DEPTH(2048), .BOOT_LOAD(1)) dut0 (
        .clk(clk), .rst(rst), .mem_addr(addr0), .mem_write(wr0), .mem_data(bus0),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(lr0), .core_rst(cr0), .load_count(lc0)
    );

    stack_mem_responder #(.ADDR_W(11), .DATA_W(16), .DEPTH(1024), .BOOT_LOAD(0)) dut1 (
        .clk(clk), .rst(rst), .mem_addr(addr1), .mem_write(wr1), .mem_data(bus1),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(lr1), .core_rst(cr1), .load_count(lc1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One bus cycle on dut0: expected value queued at drive, popped at sample.
    task automatic bus_op0(input vec_t v, input string name);
        @(negedge clk);
        wr0   = v.wr;
        en0   = v.wr;
        addr0 = v.addr;
        drv0  = v.data;
        sb_q.push_back(v.exp);
        #1;
        chk(name, bus0, sb_q.pop_front());
    endtask

    task automatic bus_op1(input vec_t v, input string name);
        @(negedge clk);
        wr1   = v.wr;
        en1   = v.wr;
        addr1 = v.addr;
        drv1  = v.data;
        sb_q.push_back(v.exp);
        #1;
        chk(name, bus1, sb_q.pop_front());
    endtask

    task automatic bus_idle();
        @(negedge clk);
        wr0 = 1'b0; en0 = 1'b0;
        wr1 = 1'b0; en1 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; load_valid = 1'b0; load_last = 1'b0;
        wr0 = 1'b0; en0 = 1'b0; wr1 = 1'b0; en1 = 1'b0;
        #1;
        chk("ready_low_in_rst", lr0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_core_rst", cr0, 1'b1);
        chk("rst_load_count", lc0, 11'd0);
        chk("rst_load_ready", lr0, 1'b1);
    endtask

    task automatic load_word(input logic [15:0] d, input logic last);
        @(negedge clk);
        load_valid = 1'b1; load_data = d; load_last = last;
    endtask

    task automatic load_gap();
        @(negedge clk);
        load_valid = 1'b0; load_last = 1'b0;
    endtask

    initial begin
        run_tbl[0] = '{1'b1, 11'h7FE, 16'h5A5A, 16'h5A5A};
        run_tbl[1] = '{1'b0, 11'h7FE, 16'h0000, 16'h5A5A};
        run_tbl[2] = '{1'b1, 11'h7FE, 16'h1234, 16'h1234};
        run_tbl[3] = '{1'b0, 11'h7FE, 16'h0000, 16'h1234};
        run_tbl[4] = '{1'b0, 11'h001, 16'h0000, 16'h0000};
        run_tbl[5] = '{1'b0, 11'h002, 16'h0000, 16'h1FFE};
        run_tbl[6] = '{1'b0, 11'h000, 16'h0000, 16'h0FFF};
        run_tbl[7] = '{1'b1, 11'h010, 16'hFFFF, 16'hFFFF};
        run_tbl[8] = '{1'b0, 11'h010, 16'h0000, 16'hFFFF};
        run_tbl[9] = '{1'b0, 11'h003, 16'h0000, 16'h0000};

        oor_tbl[0] = '{1'b0, 11'h005, 16'h0000, 16'h0000};
        oor_tbl[1] = '{1'b1, 11'h400, 16'h7777, 16'h7777};
        oor_tbl[2] = '{1'b0, 11'h400, 16'h0000, 16'h0000};
        oor_tbl[3] = '{1'b0, 11'h000, 16'h0000, 16'h0000};
        oor_tbl[4] = '{1'b1, 11'h3FF, 16'h2222, 16'h2222};
        oor_tbl[5] = '{1'b0, 11'h3FF, 16'h0000, 16'h2222};

        rst = 1'b1; load_valid = 1'b0; load_data = 16'h0000; load_last = 1'b0;
        addr0 = 11'h000; addr1 = 11'h000; wr0 = 1'b0; wr1 = 1'b0;
        en0 = 1'b0; en1 = 1'b0; drv0 = 16'h0000; drv1 = 16'h0000;

        // Test 1: three-word image, last on the third.
        do_reset();
        chk("noboot_core_rst", cr1, 1'b0);
        chk("noboot_load_ready", lr1, 1'b0);
        chk("noboot_load_count", lc1, 11'd0);
        load_word(16'h0FFF, 1'b0);
        #1;
        chk("t1_core_held", cr0, 1'b1);
        load_word(16'h0000, 1'b0);
        load_word(16'h1FFE, 1'b1);
        #1;
        chk("t1_core_held_last", cr0, 1'b1);
        chk("t1_count_before_last", lc0, 11'd2);
        load_gap();
        #1;
        chk("t1_load_count", lc0, 11'd3);
        chk("t1_core_released", cr0, 1'b0);
        chk("t1_ready_in_run", lr0, 1'b0);

        // Test 3 and general RUN traffic, table-driven.
        for (int i = 0; i < 10; i++) begin
            bus_op0(run_tbl[i], $sformatf("run_tbl[%0d]", i));
        end
        // Test 6: no-boot instance serves reads and drops unmapped writes.
        for (int i = 0; i < 6; i++) begin
            bus_op1(oor_tbl[i], $sformatf("oor_tbl[%0d]", i));
        end
        bus_idle();

        // Test 2: valid gaps write only accepted words.
        do_reset();
        load_word(16'hAAAA, 1'b0);
        load_gap();
        #1;
        chk("t2_gap1_count", lc0, 11'd1);
        chk("t2_gap1_ready", lr0, 1'b1);
        load_gap();
        #1;
        chk("t2_gap2_count", lc0, 11'd1);
        chk("t2_gap2_core_rst", cr0, 1'b1);
        en0 = 1'b1; drv0 = 16'hA5C3;
        #1;
        chk("t2_bus_released_in_load", bus0, 16'hA5C3);
        en0 = 1'b0;
        load_word(16'hBBBB, 1'b0);
        load_gap();
        #1;
        chk("t2_count", lc0, 11'd2);
        chk("t2_still_loading", cr0, 1'b1);
        load_word(16'hCCCC, 1'b1);
        load_gap();
        #1;
        chk("t2_final_count", lc0, 11'd3);
        bus_op0('{1'b0, 11'h000, 16'h0000, 16'hAAAA}, "t2_rd0");
        bus_op0('{1'b0, 11'h001, 16'h0000, 16'hBBBB}, "t2_rd1");
        bus_op0('{1'b0, 11'h002, 16'h0000, 16'hCCCC}, "t2_rd2");
        bus_op0('{1'b0, 11'h7FE, 16'h0000, 16'h1234}, "t2_retained_7fe");
        bus_idle();

        // Test 5: reset in the middle of a load.
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            load_word(16'h0100 | 16'(i), 1'b0);
        end
        load_gap();
        #1;
        chk("t5_count_before_rst", lc0, 11'd5);
        do_reset();
        load_word(16'h0F0F, 1'b1);
        load_gap();
        #1;
        chk("t5_reload_count", lc0, 11'd1);
        bus_op0('{1'b0, 11'h000, 16'h0000, 16'h0F0F}, "t5_rd0");
        bus_op0('{1'b0, 11'h001, 16'h0000, 16'h0102}, "t5_rd1");
        bus_op0('{1'b0, 11'h004, 16'h0000, 16'h0105}, "t5_rd4");
        bus_idle();

        // Test 4: full-depth image without load_last.
        do_reset();
        for (int i = 0; i < 2048; i++) begin
            load_word(16'hC000 | 16'(i), 1'b0);
            if (i == 2046) begin
                #1;
                chk("t4_not_early", lr0, 1'b1);
            end
            if (i == 2047) begin
                #1;
                chk("t4_count_at_last", lc0, 11'd2047);
                chk("t4_core_held_at_last", cr0, 1'b1);
            end
        end
        @(negedge clk);
        load_data = 16'hDEAD;
        #1;
        chk("t4_count_sat", lc0, 11'd2047);
        chk("t4_core_released", cr0, 1'b0);
        chk("t4_ready_dropped", lr0, 1'b0);
        load_gap();
        #1;
        chk("t4_count_no_wrap", lc0, 11'd2047);
        bus_op0('{1'b0, 11'h000, 16'h0000, 16'hC000}, "t4_rd0");
        bus_op0('{1'b0, 11'h400, 16'h0000, 16'hC400}, "t4_rd1024");
        bus_op0('{1'b0, 11'h7FF, 16'h0000, 16'hC7FF}, "t4_rd2047");
        bus_idle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
